// File: rtl/seq_decoder.sv
// Decodes 3-bit codes into one-hot pulses of HOLD cycles separated by GAP idle cycles,
// buffering up to two accepted codes in a small FIFO.
module seq_decoder #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i,
  input  logic       i_valid,
  output logic       i_ready,
  output logic [7:0] o,
  output logic       o_valid,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshake: a code transfers on a rising edge where i_valid and i_ready are both high;
  // i_ready depends only on registered state (and rst), so there is no pop-to-push bypass.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

  state_t     state_q, state_d;
  logic [2:0] fifo_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;
  logic [7:0] hold_q, hold_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] o_q, o_d;
  logic       o_valid_q, o_valid_d;
  logic       push, pop;
  logic [2:0] head;

  assign i_ready   = (count_q < 2'd2) && !rst;
  assign push      = i_valid && i_ready;
  assign head      = fifo_q[rd_ptr_q];
  assign o         = o_q;
  assign o_valid   = o_valid_q;
  assign busy      = !rst && ((state_q != S_IDLE) || (count_q != 2'd0));
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != 2'd0) pop = 1'b1;
      end
      S_DRIVE: begin
        if (hold_q == 8'd0) begin
          o_d       = 8'd0;
          o_valid_d = 1'b0;
          gap_d     = GAP_M1;
          state_d   = S_GAP;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) begin
          if (count_q != 2'd0) pop = 1'b1;
          else state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Starting a pulse is the same action from IDLE and from the end of a gap.
    if (pop) begin
      o_d       = 8'd1 << head;
      o_valid_d = 1'b1;
      hold_d    = HOLD_M1;
      state_d   = S_DRIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fifo_q[0] <= 3'd0;
      fifo_q[1] <= 3'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      hold_q    <= 8'd0;
      gap_q     <= 8'd0;
      o_q       <= 8'd0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
